// File: rtl/usb_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : usb_tx_arbiter_if                                               |
// | Brief    : Bus bundle between packet sources, arbiter and usb_slavefifo.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface usb_tx_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 9,
  parameter int DW   = 16
);
  logic                 en;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [AW-1:0]        rd_addr;
  logic [NREQ*DW-1:0]   rd_data;
  logic                 tx_cache_sop;
  logic [AW-1:0]        tx_cache_addr;
  logic [DW-1:0]        tx_cache_data;
  logic                 busy;
  logic                 stall_err;

  modport master (
    input  en, req, rd_data, tx_cache_addr,
    output grant, done, rd_addr, tx_cache_sop, tx_cache_data, busy, stall_err
  );

  modport slave (
    output en, req, rd_data, tx_cache_addr,
    input  grant, done, rd_addr, tx_cache_sop, tx_cache_data, busy, stall_err
  );
endinterface
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : usb_tx_arbiter                                                  |
// | Brief    : Round-robin scheduler sharing the slave-FIFO TX path.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module usb_tx_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 9,
  parameter int DW   = 16,
  parameter int GAP  = 4,
  parameter int STO  = 64,
  parameter int TW   = 16
) (
  input wire ifclk,
  input wire rst,
  usb_tx_arbiter_if.master bus
);

  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (STO > GAP) ? STO : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [TW-1:0] WD_LAST = {{(TW-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_SOP    = 3'd2,
    S_WSTART = 3'd3,
    S_GAP_R  = 3'd4,
    S_XFER   = 3'd5,
    S_WEND   = 3'd6,
    S_GAP    = 3'd7
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [NREQ-1:0] grant_vec;
  logic [NREQ-1:0] done_vec;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   pick;
  logic            found;
  logic [CW-1:0]   cnt;
  logic            sop;
  logic [TW-1:0]   wd_cnt;
  logic [AW-1:0]   prev_addr;
  logic            stall;
  logic            load_grant;
  logic            retire;
  logic            addr_zero;
  logic            addr_ones;
  logic            cnt_gap_end;
  logic            cnt_sto_end;
  logic [DW-1:0]   data_mux;
  int              idx;

  assign addr_zero   = (bus.tx_cache_addr == '0);
  assign addr_ones   = (bus.tx_cache_addr == '1);
  assign cnt_gap_end = (cnt == CW'(GAP - 1));
  assign cnt_sto_end = (cnt == CW'(STO - 1));

  // Round-robin search starts just past the last owner.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_n    = state;
    load_grant = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE:   if (bus.en && (|bus.req)) state_n = S_ARB;
      S_ARB: begin
        if (found) begin
          state_n    = S_SOP;
          load_grant = 1'b1;
        end else begin
          state_n    = S_IDLE;
        end
      end
      S_SOP:    state_n = S_WSTART;
      S_WSTART: begin
        if (!addr_zero)       state_n = S_XFER;
        else if (cnt_sto_end) state_n = S_GAP_R;
      end
      S_GAP_R:  if (cnt_gap_end) state_n = S_SOP;
      S_XFER:   if (addr_ones) state_n = S_WEND;
      S_WEND: begin
        if (addr_zero) begin
          state_n = S_GAP;
          retire  = 1'b1;
        end
      end
      S_GAP:    if (cnt_gap_end) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ifclk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      grant_vec <= '0;
      done_vec  <= '0;
      ptr       <= PW'(NREQ - 1);
      cnt       <= '0;
      sop       <= 1'b0;
      wd_cnt    <= '0;
      prev_addr <= '0;
      stall     <= 1'b0;
    end else begin
      state    <= state_n;
      sop      <= (state_n == S_SOP);
      done_vec <= retire ? grant_vec : '0;

      if (load_grant) begin
        grant_vec <= NREQ'(1) << pick;
        ptr       <= pick;
      end else if (retire) begin
        grant_vec <= '0;
      end

      if (state_n != state)  cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + 1'b1;

      // Watchdog only reports; the transfer is never aborted.
      prev_addr <= bus.tx_cache_addr;
      stall     <= 1'b0;
      if (state == S_XFER && bus.tx_cache_addr == prev_addr) begin
        if (wd_cnt == WD_LAST) begin
          wd_cnt <= '0;
          stall  <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vec[i]) data_mux = data_mux | bus.rd_data[i*DW +: DW];
    end
  end

  assign bus.grant         = grant_vec;
  assign bus.done          = done_vec;
  assign bus.tx_cache_sop  = sop;
  assign bus.stall_err     = stall;
  assign bus.busy          = (state != S_IDLE);
  assign bus.rd_addr       = bus.tx_cache_addr;
  assign bus.tx_cache_data = data_mux;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_usb_tx_arbiter                                               |
// | Brief    : Randomized scoreboard bench with slave-FIFO model for arbiter.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_usb_tx_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int GAP  = 4;
  localparam int STO  = 64;
  localparam int TW   = 8;
  localparam int LAST = (1 << AW) - 1;

  logic ifclk = 1'b0;
  logic rst   = 1'b1;
  always #5 ifclk = ~ifclk;

  usb_tx_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  usb_tx_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .GAP(GAP), .STO(STO), .TW(TW)) dut (
    .ifclk (ifclk),
    .rst   (rst),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] pat(input int i, input logic [AW-1:0] a);
    return DW'((i + 1) * 'h1000) ^ DW'(a);
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_src
    assign bus.rd_data[g*DW +: DW] = pat(g, bus.rd_addr);
  end

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int grant_log[$];
  int m_ptr = NREQ - 1;
  int stim_owner = -1;
  int done_cnt = 0;
  int stall_cnt = 0;
  bit m_ignore, m_rereq, m_rand, m_endrop, m_sop_seen;
  int m_freeze, m_rst_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired got no event expected event", name);
  endtask

  // Reference model: next owner is the first requester after the last one served.
  function automatic int predict(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(m_ptr + k) % NREQ]) begin
        m_ptr = (m_ptr + k) % NREQ;
        return m_ptr;
      end
    end
    return -1;
  endfunction

  task automatic push_pred();
    stim_owner = predict(bus.req);
    exp_q.push_back(stim_owner);
  endtask

  // Monitor / scoreboard
  logic [NREQ-1:0] prev_grant;
  logic prev_sop, have_sop, active;
  int cur_owner, low_cnt;

  always @(negedge ifclk) begin
    if (rst) begin
      prev_grant = '0; prev_sop = 1'b0; have_sop = 1'b0;
      active = 1'b0; cur_owner = -1; low_cnt = 0;
    end else begin
      chk("grant_onehot", 32'($countones(bus.grant) <= 1), 1);
      chk("rd_addr", 32'(bus.rd_addr), 32'(bus.tx_cache_addr));
      if (bus.done != '0) begin
        done_cnt++;
        chk("done_owner", 32'(bus.done), active ? (1 << cur_owner) : 0);
        chk("done_grant_clear", 32'(bus.grant), 0);
        active = 1'b0;
      end
      if (prev_grant == '0 && bus.grant != '0) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", 32'(bus.grant), 0);
        end else begin
          cur_owner = exp_q.pop_front();
          grant_log.push_back(cur_owner);
          chk("grant", 32'(bus.grant), 1 << cur_owner);
          chk("grant_with_sop", 32'(bus.tx_cache_sop), 1);
          active = 1'b1;
        end
      end else if (prev_grant != '0 && bus.grant != '0) begin
        chk("grant_hold", 32'(bus.grant), 32'(prev_grant));
      end
      chk("tx_data", 32'(bus.tx_cache_data), active ? 32'(pat(cur_owner, bus.tx_cache_addr)) : 0);
      if (bus.tx_cache_sop) begin
        chk("sop_width", 32'(prev_sop), 0);
        if (!prev_sop && have_sop) chk("sop_gap", 32'(low_cnt >= GAP), 1);
        have_sop = 1'b1;
        low_cnt  = 0;
      end else begin
        low_cnt++;
      end
      if (bus.stall_err) stall_cnt++;
      prev_grant = bus.grant;
      prev_sop   = bus.tx_cache_sop;
    end
  end

  task automatic tick();
    @(posedge ifclk);
    #1;
  endtask

  task automatic wait_sop(input int limit, output int waited, output bit ok);
    ok = 1'b0;
    waited = 0;
    while (waited < limit && !ok) begin
      tick();
      waited++;
      if (bus.tx_cache_sop) ok = 1'b1;
    end
    if (!ok) timeout_fail("sop_wait");
  endtask

  task automatic clr_mode();
    m_ignore = 0; m_rereq = 0; m_rand = 0; m_endrop = 0; m_sop_seen = 0;
    m_freeze = 0; m_rst_at = 0;
  endtask

  // Slave-FIFO model: one packet from sop to wrap, then the source reacts to done.
  task automatic packet(output bit aborted);
    int w, sc0, dc0;
    bit ok;
    aborted = 1'b0;
    if (!m_sop_seen) begin
      wait_sop(300, w, ok);
      if (!ok) begin aborted = 1'b1; return; end
    end
    if (m_ignore) begin
      wait_sop(STO + GAP + 40, w, ok);
      if (!ok) begin aborted = 1'b1; return; end
      chk("retry_sop_dist", w, STO + GAP + 1);
    end
    for (int a = 1; a <= LAST; a++) begin
      bus.tx_cache_addr = AW'(a);
      if (a == 256 && m_rand) begin
        for (int i = 0; i < NREQ; i++)
          if (i != stim_owner && !bus.req[i] && ($urandom % 2) == 1) bus.req[i] = 1'b1;
      end
      if (a == 256 && m_endrop) bus.en = 1'b0;
      if (a == m_rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_sop", 32'(bus.tx_cache_sop), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        aborted = 1'b1;
        return;
      end
      if (a == 100 && m_freeze > 0) begin
        sc0 = stall_cnt;
        dc0 = done_cnt;
        repeat (m_freeze) tick();
        chk("stall_pulses", stall_cnt - sc0, 1);
        chk("no_done_in_stall", done_cnt - dc0, 0);
      end
      tick();
    end
    bus.tx_cache_addr = '0;
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      tick();
      if (bus.done != '0) ok = 1'b1;
    end
    if (!ok) begin timeout_fail("done_wait"); aborted = 1'b1; return; end
    bus.req[stim_owner] = m_rereq;
    if (bus.en && bus.req != '0) push_pred();
  endtask

  task automatic drain();
    bit ab;
    for (int n = 0; n < 2 * NREQ && bus.req != '0; n++) begin
      clr_mode();
      packet(ab);
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    bit ab;
    int n, first_owner;
    clr_mode();
    bus.en = 1'b1;
    bus.req = '0;
    bus.tx_cache_addr = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_grant", 32'(bus.grant), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_sop", 32'(bus.tx_cache_sop), 0);
    chk("reset_stall", 32'(bus.stall_err), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    repeat (2) tick();

    // single requester: latency and gap after done
    bus.req = 3'b001;
    push_pred();
    tick();
    chk("lat_grant_c1", 32'(bus.grant), 0);
    tick();
    chk("lat_grant_c2", 32'(bus.grant), 3'b001);
    chk("lat_sop_c2", 32'(bus.tx_cache_sop), 1);
    m_sop_seen = 1;
    packet(ab);
    n = 0;
    while (bus.busy && n < 20) begin tick(); n++; end
    chk("gap_to_idle", n, GAP);

    // two requesters held: alternation
    grant_log.delete();
    bus.req = 3'b011;
    push_pred();
    for (int p = 0; p < 4; p++) begin
      clr_mode();
      m_rereq = 1;
      packet(ab);
    end
    chk("alt_0", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    chk("alt_1", grant_log.size() > 1 ? grant_log[1] : -1, 0);
    chk("alt_2", grant_log.size() > 2 ? grant_log[2] : -1, 1);
    chk("alt_3", grant_log.size() > 3 ? grant_log[3] : -1, 0);
    drain();

    // first sop ignored by slave
    repeat (GAP + 4) tick();
    bus.req = 3'b001;
    push_pred();
    clr_mode();
    m_ignore = 1;
    packet(ab);

    // stalled address
    repeat (GAP + 4) tick();
    bus.req = 3'b010;
    push_pred();
    clr_mode();
    m_freeze = 300;
    packet(ab);

    // en dropped mid-packet
    repeat (GAP + 4) tick();
    bus.req = 3'b011;
    push_pred();
    first_owner = stim_owner;
    clr_mode();
    m_endrop = 1;
    packet(ab);
    repeat (20) tick();
    chk("en_low_grant", 32'(bus.grant), 0);
    chk("en_low_busy", 32'(bus.busy), 0);
    bus.en = 1'b1;
    push_pred();
    chk("en_other_owner", 32'(stim_owner != first_owner), 1);
    clr_mode();
    packet(ab);
    drain();

    // reset mid-packet
    repeat (GAP + 4) tick();
    bus.req = 3'b001;
    push_pred();
    clr_mode();
    m_rst_at = 300;
    packet(ab);
    exp_q.delete();
    m_ptr = NREQ - 1;
    bus.req = '0;
    bus.tx_cache_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    bus.req = 3'b001;
    push_pred();
    clr_mode();
    packet(ab);
    chk("post_rst_owner", grant_log[grant_log.size() - 1], 0);

    // randomized traffic
    for (int p = 0; p < 10; p++) begin
      if (bus.req == '0) begin
        repeat ($urandom_range(8, 1)) tick();
        bus.req = NREQ'($urandom_range((1 << NREQ) - 1, 1));
        push_pred();
      end
      clr_mode();
      m_rand = 1;
      m_rereq = ($urandom % 2) == 1;
      packet(ab);
    end
    drain();

    repeat (20) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("stall_total", stall_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
